// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants: instruction format codes, canonical NOP and base opcodes.
package rv32_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/instruction_pack.sv
// Combinational RV32I field packer with immediate range check.
// Out-of-range immediates are still packed from their truncated bits, with err_o raised.
module instruction_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic imm12_ok;
  logic imm13_ok;
  logic imm21_ok;

  // An immediate fits N signed bits when every bit above bit N-1 matches the sign bit.
  assign imm12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign imm13_ok = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
  assign imm21_ok = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);

  always_comb begin
    instr_o = NOP;
    err_o   = 1'b1;
    case (fmt_i)
      FMT_R: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        err_o   = 1'b0;
      end
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        err_o   = !imm12_ok;
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        err_o   = !imm12_ok;
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        err_o   = imm_i[0] || !imm13_ok;
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        err_o   = (imm_i[11:0] != 12'h000);
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        err_o   = imm_i[0] || !imm21_ok;
      end
      default: begin
        instr_o = NOP;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streams packed RV32I words with byte addresses through a 2-entry output buffer.
// in_ready depends only on buffer occupancy, clear and reset, never on out_ready.
module instruction_encoder
  import rv32_pkg::*;
#(
  parameter int          BITWIDTH  = 32,
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          fmt,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [31:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [15:0]         word_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0] enc_instr;
  logic        enc_err;

  logic [1:0]          occ_q, occ_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [15:0]         count_q, count_d;
  logic [BITWIDTH-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [ADDR_W-1:0]   addr0_q, addr0_d, addr1_q, addr1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                push, pop;

  instruction_pack u_pack (
    .fmt_i    (fmt),
    .opcode_i (opcode),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .imm_i    (imm),
    .instr_o  (enc_instr),
    .err_o    (enc_err)
  );

  assign in_ready   = rst_n && (occ_q != 2'd2) && !clear;
  assign out_valid  = (occ_q != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready && !clear;
  assign out_instr  = instr0_q;
  assign out_addr   = addr0_q;
  assign out_err    = err0_q;
  assign word_count = count_q;

  always_comb begin
    occ_d       = occ_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    instr0_d    = instr0_q;
    addr0_d     = addr0_q;
    err0_d      = err0_q;
    instr1_d    = instr1_q;
    addr1_d     = addr1_q;
    err1_d      = err1_q;
    if (clear) begin
      occ_d       = 2'd0;
      next_addr_d = BASE;
      count_d     = 16'd0;
    end else begin
      if (pop) begin
        count_d  = count_q + 16'd1;
        instr0_d = instr1_q;
        addr0_d  = addr1_q;
        err0_d   = err1_q;
      end
      if (push) begin
        next_addr_d = next_addr_q + ADDR_W'(4);
        // New word lands at the head when the buffer is (or is becoming) empty.
        if (occ_q == 2'd0 || pop) begin
          instr0_d = BITWIDTH'(enc_instr);
          addr0_d  = next_addr_q;
          err0_d   = enc_err;
        end else begin
          instr1_d = BITWIDTH'(enc_instr);
          addr1_d  = next_addr_q;
          err1_d   = enc_err;
        end
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= 2'd0;
      next_addr_q <= BASE;
      count_q     <= 16'd0;
      instr0_q    <= '0;
      addr0_q     <= '0;
      err0_q      <= 1'b0;
      instr1_q    <= '0;
      addr1_q     <= '0;
      err1_q      <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      instr0_q    <= instr0_d;
      addr0_q     <= addr0_d;
      err0_q      <= err0_d;
      instr1_q    <= instr1_d;
      addr1_q     <= addr1_d;
      err1_q      <= err1_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vector table, backpressure/clear/reset sequences,
// and a randomized stream checked against an arithmetic reference encoder and a queue.
module tb_instruction_encoder;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_instr;
  logic [15:0] out_addr, word_count;

  int n_cmp = 0;
  int n_fail = 0;

  instruction_encoder #(.BITWIDTH(32), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] addr;
    logic        err;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [2:0] f, logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                              logic [31:0] im, logic [31:0] ei, logic ee);
    vec_t v;
    v.name = nm; v.fmt = f; v.op = op; v.f3 = f3; v.f7 = f7;
    v.rd = d; v.rs1 = s1; v.rs2 = s2; v.imm = im; v.exp_instr = ei; v.exp_err = ee;
    return v;
  endfunction

  // Reference encoder written from the format rules with shifts, masks and signed ranges.
  function automatic exp_t model(logic [2:0] f, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                 logic [4:0] d, logic [4:0] s1, logic [4:0] s2, logic [31:0] im);
    exp_t e;
    int v = int'(im);
    bit [31:0] u = im;
    bit [31:0] base = (32'(f3) << 12) | 32'(op);
    e.addr = 16'h0;
    case (f)
      3'd0: begin
        e.instr = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base;
        e.err = 1'b0;
      end
      3'd1: begin
        e.instr = ((u & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base;
        e.err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        e.instr = (((u >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                | ((u & 32'h1F) << 7) | base;
        e.err = (v < -2048) || (v > 2047);
      end
      3'd3: begin
        e.instr = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                | (32'(s1) << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | base;
        e.err = ((u & 1) != 0) || (v < -4096) || (v > 4095);
      end
      3'd4: begin
        e.instr = (u & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
        e.err = (u & 32'hFFF) != 0;
      end
      3'd5: begin
        e.instr = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                | (32'(d) << 7) | 32'(op);
        e.err = ((u & 1) != 0) || (v < -(1 << 20)) || (v >= (1 << 20));
      end
      default: begin
        e.instr = 32'h0000_0013;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic drive(input vec_t v);
    fmt = v.fmt; opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  // Offer one word for one clock; returns after the active edge.
  task automatic offer(input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    exp_t e0, e1;
    vec_t w[3];
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

    vecs[0] = mk("addi",    FMT_I, OP_IMM,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        32'h0050_0093, 1'b0);
    vecs[1] = mk("add",     FMT_R, OP_REG,    3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h0020_81B3, 1'b0);
    vecs[2] = mk("sw",      FMT_S, OP_STORE,  3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_A423, 1'b0);
    vecs[3] = mk("beq",     FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_8463, 1'b0);
    vecs[4] = mk("jal",     FMT_J, OP_JAL,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16,       32'h0100_00EF, 1'b0);
    vecs[5] = mk("lui",     FMT_U, OP_LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[6] = mk("b_odd",   FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7,        32'h0020_8363, 1'b1);
    vecs[7] = mk("i_2048",  FMT_I, OP_IMM,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h8000_0093, 1'b1);
    vecs[8] = mk("u_low",   FMT_U, OP_LUI,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd1,        32'h0000_02B7, 1'b1);
    vecs[9] = mk("fmt7",    3'd7,  OP_REG,    3'd1, 7'd5, 5'd3, 5'd4, 5'd6, 32'd99,       32'h0000_0013, 1'b1);

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_word_count", word_count, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed table: one word at a time, out_ready high, 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, out_valid, 1);
      chk({vecs[i].name, "_instr"}, out_instr, vecs[i].exp_instr);
      chk({vecs[i].name, "_addr"}, out_addr, 32'(4 * i));
      chk({vecs[i].name, "_err"}, out_err, vecs[i].exp_err);
    end
    @(negedge clk);
    chk("table_count", word_count, 10);
    chk("table_drained", out_valid, 0);

    // Clear, then backpressure with three offers.
    @(negedge clk) clear = 1'b1;
    @(posedge clk) #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_count", word_count, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w[k] = mk("bp", FMT_I, OP_IMM, 3'd0, 7'd0, 5'(k + 1), 5'd2, 5'd0, 32'(k * 3 + 1), 32'h0, 1'b0);
      @(negedge clk);
      drive(w[k]);
      in_valid = 1'b1;
      #1 chk("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    e0 = model(w[0].fmt, w[0].op, w[0].f3, w[0].f7, w[0].rd, w[0].rs1, w[0].rs2, w[0].imm);
    e1 = model(w[1].fmt, w[1].op, w[1].f3, w[1].f7, w[1].rd, w[1].rs1, w[1].rs2, w[1].imm);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_instr", out_instr, e0.instr);
      chk("bp_hold_addr", out_addr, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_instr", out_instr, e1.instr);
    chk("bp_second_addr", out_addr, 4);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);
    chk("bp_count", word_count, 2);

    // Clear with a buffered word, a pending pop and a pending push.
    out_ready = 1'b0;
    offer(vecs[0]);
    @(negedge clk);
    chk("pre_clr_addr", out_addr, 8);
    drive(vecs[1]);
    in_valid = 1'b1; out_ready = 1'b1; clear = 1'b1;
    #1 chk("clr_in_ready", in_ready, 0);
    @(posedge clk) #1 begin clear = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_word_count", word_count, 0);
    offer(vecs[2]);
    @(negedge clk);
    chk("post_clr_addr", out_addr, 0);
    chk("post_clr_instr", out_instr, vecs[2].exp_instr);

    // Reset in the middle of a stream.
    out_ready = 1'b0;
    offer(vecs[3]);
    offer(vecs[4]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_emit", out_valid, 0);
    chk("midrst_count", word_count, 0);

    // Randomized stream against the reference model and a scoreboard queue.
    begin
      int pushed = 0;
      int popped = 0;
      for (int n = 0; n < 500; n++) begin
        exp_t e;
        @(negedge clk);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        fmt = 3'($urandom_range(0, 7));
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
          0: imm = $urandom;
          1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
          2: imm = 32'(int'($urandom_range(0, 4194303)) - 2097152) & 32'hFFFF_FFFE;
          default: imm = {20'($urandom), 12'h000};
        endcase
        #1;
        chk("rnd_in_ready", in_ready, (sb.size() < 2) ? 1 : 0);
        chk("rnd_out_valid", out_valid, (sb.size() != 0) ? 1 : 0);
        if (sb.size() != 0 && out_ready) begin
          e = sb.pop_front();
          chk("rnd_instr", out_instr, e.instr);
          chk("rnd_addr", out_addr, e.addr);
          chk("rnd_err", out_err, e.err);
          popped++;
        end
        if (in_valid && (sb.size() + ((out_ready && out_valid) ? 1 : 0)) < 3 && in_ready) begin
          e = model(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
          e.addr = 16'(pushed * 4);
          sb.push_back(e);
          pushed++;
        end
        @(posedge clk);
        #1 chk("rnd_count", word_count, 32'(popped & 16'hFFFF));
      end
      in_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
